// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter producing the registered one-hot select for onehot_mux.
// Latency: 1 cycle from req to grant; back-to-back grants for distinct requesters.
// Backpressure: o_ready low freezes grant and ptr; busy_cnt counts stalled cycles.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req         per-channel request level (held until ack)
//   o_ready     downstream accepts the current beat
//   i_last      last beat of the granted packet (only used with ARB_HOLD_EN)
//   grant       registered one-hot (or all-zero) mux select
//   o_valid     |grant, qualifies the mux output
//   ack         per-channel pop pulse, grant gated by the transfer
//   busy_cnt    saturating count of consecutive stalled cycles
//
// Build option: define ARB_HOLD_EN to keep the grant for a whole packet
// (re-arbitration only on the beat with i_last set).
module onehot_rr_arbiter #(
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                o_ready,
    input  logic                i_last,
    output logic [CHANNELS-1:0] grant,
    output logic                o_valid,
    output logic [CHANNELS-1:0] ack,
    output logic [7:0]          busy_cnt
);

    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [CHANNELS-1:0] grant_q, grant_n;
    logic [PTR_W-1:0]    ptr, ptr_n;
    logic [7:0]          busy_q, busy_n;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    nxt_ptr;
    logic [CHANNELS-1:0] idle_pick;
    logic [CHANNELS-1:0] xfer_pick;
    logic                xfer;
    logic                rearb;

    // First set bit of mask scanning base, base+1, ... modulo CHANNELS.
    // Rotate so that base lands on bit 0, take the lowest set bit, rotate back.
    function automatic logic [CHANNELS-1:0] pick(
        input logic [CHANNELS-1:0] mask,
        input logic [PTR_W-1:0]    base
    );
        logic [2*CHANNELS-1:0] dbl;
        logic [CHANNELS-1:0]   rot;
        logic [CHANNELS-1:0]   sel;
        logic                  found;
        dbl   = {mask, mask} >> base;
        rot   = dbl[CHANNELS-1:0];
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && rot[i]) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        dbl = {sel, sel} << base;
        return dbl[2*CHANNELS-1:CHANNELS];
    endfunction

    assign grant    = grant_q;
    assign o_valid  = |grant_q;
    assign busy_cnt = busy_q;
    assign xfer     = o_valid & o_ready;
    assign ack      = grant_q & {CHANNELS{xfer}};

`ifdef ARB_HOLD_EN
    assign rearb = i_last;
`else
    logic unused_last;
    assign unused_last = i_last;
    assign rearb       = 1'b1;
`endif

    // Index of the current winner (grant is one-hot while in GRANT).
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_q[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    assign nxt_ptr   = (win_idx == PTR_W'(CHANNELS - 1)) ? '0 : win_idx + 1'b1;
    assign idle_pick = pick(req, ptr);
    // Masking out the winner keeps a lone requester from winning two beats
    // in a row; it re-enters through IDLE after one bubble.
    assign xfer_pick = pick(req & ~grant_q, nxt_ptr);

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        ptr_n   = ptr;
        busy_n  = busy_q;
        case (state)
            IDLE: begin
                busy_n = '0;
                if (|req) begin
                    grant_n = idle_pick;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!o_ready) begin
                    // Grant and ptr frozen even if req drops early.
                    busy_n = (busy_q == 8'hFF) ? busy_q : busy_q + 8'd1;
                end else begin
                    busy_n = '0;
                    if (rearb) begin
                        ptr_n   = nxt_ptr;
                        grant_n = xfer_pick;
                        if (xfer_pick == '0) begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                busy_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= '0;
            busy_q  <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            ptr     <= ptr_n;
            busy_q  <= busy_n;
        end
    end

    grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule
